// File: rtl/matrix_multiply_4x4.sv
// Sequential fixed-point 4x4 matrix multiplier, C = A * B, one output element per clock.
// Four parallel signed multipliers feed an adder tree with round-half-up and saturation.
module matrix_multiply_4x4 #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int DIM        = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] A,
   input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] B,
   output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] C,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    overflow
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + 2;

   localparam logic signed [AW-1:0] RND   = {{(AW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
   localparam logic signed [AW-1:0] MAX_V = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MIN_V = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] mat_t;
   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

   state_t     state_q;
   mat_t       a_q, b_q, res_q, c_q;
   logic [3:0] idx_q;
   logic       ovf_acc_q, ovf_q, busy_q, done_q;

   logic [1:0] row, col;
   assign row = idx_q[3:2];
   assign col = idx_q[1:0];

   logic signed [PW-1:0] prod [DIM];

   generate
      for (genvar gi = 0; gi < DIM; gi++) begin : g_mul
         logic signed [PW-1:0] a_ext, b_ext;
         assign a_ext    = {{DATA_WIDTH{a_q[row][gi][DATA_WIDTH-1]}}, a_q[row][gi]};
         assign b_ext    = {{DATA_WIDTH{b_q[gi][col][DATA_WIDTH-1]}}, b_q[gi][col]};
         assign prod[gi] = a_ext * b_ext;
      end
   endgenerate

   logic signed [AW-1:0]   acc_d, rnd_d, shifted_d;
   logic [DATA_WIDTH-1:0]  elem_d;
   logic                   elem_sat_d;

   always_comb begin
      acc_d = '0;
      for (int k = 0; k < DIM; k++) begin
         acc_d = acc_d + {{2{prod[k][PW-1]}}, prod[k]};
      end
      rnd_d      = acc_d + RND;
      shifted_d  = rnd_d >>> FRAC_BITS;
      elem_d     = shifted_d[DATA_WIDTH-1:0];
      elem_sat_d = 1'b0;
      // Exact most-negative value fits, so only values strictly beyond the range clip
      if (shifted_d > MAX_V) begin
         elem_d     = MAX_V[DATA_WIDTH-1:0];
         elem_sat_d = 1'b1;
      end else if (shifted_d < MIN_V) begin
         elem_d     = MIN_V[DATA_WIDTH-1:0];
         elem_sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         c_q       <= '0;
         idx_q     <= '0;
         ovf_acc_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q       <= A;
                  b_q       <= B;
                  idx_q     <= '0;
                  ovf_acc_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               res_q[row][col] <= elem_d;
               idx_q           <= idx_q + 4'd1;
               if (elem_sat_d) ovf_acc_q <= 1'b1;
               if (idx_q == 4'd15) begin
                  // Publish the whole product at once, last element taken straight from the tree
                  c_q           <= res_q;
                  c_q[row][col] <= elem_d;
                  ovf_q         <= ovf_acc_q | elem_sat_d;
                  done_q        <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign C        = c_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule
